key_event_ctrl: RTL and testbench
=================================

Name: key_event_ctrl

Overview:
- Sequences the outputs of the per-key debounce filters into one ordered key-event stream for the water-level control FSM.
- Each key's debounced press pulse and stable flag are classified as a short or long press.
- Simultaneous key events are arbitrated round-robin.
- Events are buffered in a small FIFO behind a valid/ready handshake, so the control FSM never misses a key.

Parameters:
- NUM_KEYS, 4: number of debounced keys (2..8).
- ID_W, 2: key index width, = clog2(NUM_KEYS).
- LONG_CYC, 50: cycles key_stable must stay high after the press pulse for a long press (>=2).
- CNT_W, 6: hold-counter width; must hold LONG_CYC-1.
- FIFO_DEPTH, 4: event FIFO entries (power of 2).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- key_press, input, NUM_KEYS: per-key single-cycle press pulse from the debounce filters.
- key_stable, input, NUM_KEYS: per-key debounced "held" level from the debounce filters.
- evt_valid, output, 1: FIFO head event available.
- evt_ready, input, 1: consumer accepts the head event this cycle.
- evt_key, output, ID_W: key index of the head event.
- evt_long, output, 1: 1 = long press, 0 = short press.
- fifo_full, output, 1: FIFO holds FIFO_DEPTH entries.
- overflow, output, 1: sticky flag, an event was dropped.
- clr_ovf, input, 1: synchronous clear of overflow.

Behaviour:
- Reset (reset=0, async):
  - All per-key FSMs go to IDLE; hold counters = 0; pending bits = 0.
  - RR pointer = 0; FIFO empty.
  - evt_valid = 0, evt_key = 0, evt_long = 0, fifo_full = 0, overflow = 0.
  - Reset asserted mid-operation discards all queued and pending events.
- Per-key FSM (one instance per key, all identical):
  - IDLE: on key_press[i]=1, go to HELD with cnt=0. key_stable alone does nothing.
  - HELD, key_stable[i]=0: raise a short event; go to IDLE.
  - HELD, key_stable[i]=1 and cnt==LONG_CYC-1: raise a long event; go to WAIT_REL.
  - HELD, otherwise: cnt increments.
  - WAIT_REL: on key_stable[i]=0, go to IDLE. Never raises a second event.
  - key_press[i] is ignored in HELD and WAIT_REL.
- Raising an event:
  - Sets pending[i] and pend_long[i] at that clock edge.
  - If pending[i] is already set, the new event is dropped, the old one is kept, and overflow is set.
- Arbiter (at most one grant per cycle, only when the FIFO is not full):
  - Searches pending bits cyclically, starting at the RR pointer.
  - The winner {i, pend_long[i]} is written to the FIFO and pending[i] is cleared on the same edge.
  - Pointer becomes (i+1) mod NUM_KEYS.
  - When no grant is issued, the pointer holds.
  - A key may raise a new event in the same cycle its pending bit is granted. The new event sets pending again and is not an overflow.
- FIFO (show-ahead):
  - evt_key and evt_long reflect the head entry whenever evt_valid=1, and hold stable until accepted.
  - Pop occurs when evt_valid & evt_ready.
  - Simultaneous push and pop is allowed whenever not full. Count is unchanged.
  - Pushing is blocked while full, even if a pop occurs in that cycle; pending events wait.
  - Pointers wrap modulo FIFO_DEPTH.
  - evt_ready while empty has no effect.
- Latency:
  - Short event: key_stable sampled low at edge E -> pending at E -> FIFO write at E+1 -> evt_valid high after E+1.
  - With FIFO empty and no competing key, that is 2 cycles from the release edge.
  - Long event: evt_valid rises LONG_CYC+2 edges after the edge that samples key_press.
- overflow: set by a drop, cleared by clr_ovf. If a drop and clr_ovf occur in the same cycle, set wins.

Decomposition:
- Shared package/include key_evt_pkg:
  - NUM_KEYS, ID_W, LONG_CYC defaults.
  - Key-FSM state encodings IDLE=2'd0, HELD=2'd1, WAIT_REL=2'd2.
  - Event word layout {long, key_id}, width ID_W+1.
- Sub-module key_evt_fifo: parameterised show-ahead synchronous FIFO (WIDTH, DEPTH) with full, empty and count outputs.
- Per-key FSMs are generated instances inside key_event_ctrl; the arbiter stays inline.

Test Plan:
- Short press: key 1 press pulse with stable high for 10 cycles, then low; evt_ready=1 -> one event key=1, long=0, evt_valid 2 cycles after the release edge, held for 1 cycle.
- Long press: key 2 stable held 120 cycles with LONG_CYC=50 -> exactly one event key=2, long=1, at press+52 edges; release produces no further event.
- Simultaneous release: keys 0, 1 and 3 release on the same edge, pointer=0 -> FIFO order 0, 1, 3 on consecutive cycles; pointer ends at 0.
- Backpressure: evt_ready=0, 6 short events on distinct keys in sequence with depth 4 -> fifo_full=1 after 4 events; remaining pending bits held, overflow=0. Raising evt_ready drains all 6 in order with no loss.
- Overflow: FIFO full and key 0 pending, then key 0 produces another short event -> overflow=1 and a single queued key-0 event. clr_ovf pulse -> overflow=0.
- Reset mid-stream: 3 queued events and key 1 in HELD, assert reset for 1 cycle -> evt_valid=0 immediately and no events after release; key 1 returns to IDLE.

Source files
------------

// File: rtl/key_evt_pkg.sv
// Shared definitions for the key-event sequencer: default sizing,
// per-key FSM state encoding and the event word layout.
package key_evt_pkg;

  localparam int NUM_KEYS_DEF   = 4;
  localparam int ID_W_DEF       = 2;
  localparam int LONG_CYC_DEF   = 50;
  localparam int CNT_W_DEF      = 6;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    WAIT_REL = 2'd2
  } key_state_e;

  // Event word is {long, key_id}: the long flag sits just above the key index.
  function automatic int evt_w(input int id_w);
    return id_w + 1;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Show-ahead synchronous FIFO. The head entry is visible on dout_o whenever
// the FIFO is not empty; a push into a full FIFO is ignored, even if a pop
// happens in the same cycle.
module key_evt_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage, pointers (wrap naturally since DEPTH is a power of 2) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Turns debounced key press pulses / held levels into an ordered stream of
// short/long key events for the water-level control FSM.
//
// Per-key FSM states:
//   state    | meaning
//   IDLE     | waiting for a press pulse
//   HELD     | pressed, counting hold cycles; release -> short event
//   WAIT_REL | long event already raised, waiting for release
module key_event_ctrl
  import key_evt_pkg::*;
#(
  parameter int NUM_KEYS   = NUM_KEYS_DEF,
  parameter int ID_W       = ID_W_DEF,
  parameter int LONG_CYC   = LONG_CYC_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_press,
  input  logic [NUM_KEYS-1:0] key_stable,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [ID_W-1:0]     evt_key,
  output logic                evt_long,
  output logic                fifo_full,
  output logic                overflow,
  input  logic                clr_ovf
);

  localparam int EVT_W = evt_w(ID_W);
  localparam int FAW   = $clog2(FIFO_DEPTH);

  logic [NUM_KEYS-1:0]   raise_short;
  logic [NUM_KEYS-1:0]   raise_long;
  logic [NUM_KEYS-1:0]   raise;

  logic [NUM_KEYS-1:0]   pending_q,   pending_d;
  logic [NUM_KEYS-1:0]   pend_long_q, pend_long_d;
  logic [ID_W-1:0]       rr_q,        rr_d;
  logic                  overflow_q,  overflow_d;

  logic [NUM_KEYS-1:0]   pend_kept;
  logic [NUM_KEYS-1:0]   drop;
  logic [2*NUM_KEYS-1:0] pend_dbl;
  logic [NUM_KEYS-1:0]   pend_rot;
  logic                  grant_vld;
  logic [ID_W-1:0]       grant_off;
  logic [ID_W:0]         grant_sum;
  logic [ID_W-1:0]       grant_idx;
  logic [NUM_KEYS-1:0]   grant_oh;

  logic [EVT_W-1:0]      push_word;
  logic [EVT_W-1:0]      head_word;
  logic                  fifo_empty;
  logic                  fifo_full_w;
  logic [FAW:0]          fifo_cnt;
  logic                  fifo_room;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             at_long;

    assign at_long = (cnt_q == CNT_W'(LONG_CYC - 1));

    // Press/hold classification for one key; press pulses are ignored once armed.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (key_press[g]) begin
              state_q <= HELD;
              cnt_q   <= '0;
            end
          end
          HELD: begin
            if (!key_stable[g])  state_q <= IDLE;
            else if (at_long)    state_q <= WAIT_REL;
            else                 cnt_q   <= cnt_q + CNT_W'(1);
          end
          WAIT_REL: begin
            if (!key_stable[g]) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign raise_short[g] = (state_q == HELD) && !key_stable[g];
    assign raise_long[g]  = (state_q == HELD) &&  key_stable[g] && at_long;
  end

  assign raise = raise_short | raise_long;

  // Round-robin search: rotate pending so the RR pointer lands on bit 0,
  // take the lowest set bit, then map the offset back to a key index.
  assign pend_dbl  = {pending_q, pending_q} >> rr_q;
  assign pend_rot  = pend_dbl[NUM_KEYS-1:0];
  assign fifo_room = (fifo_cnt != (FAW+1)'(FIFO_DEPTH));

  // Pick the first pending key at or after the pointer when the FIFO has room.
  always_comb begin
    grant_vld = 1'b0;
    grant_off = '0;
    if (fifo_room) begin
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
        if (pend_rot[k]) begin
          grant_vld = 1'b1;
          grant_off = ID_W'(k);
        end
      end
    end
  end

  assign grant_sum = {1'b0, rr_q} + {1'b0, grant_off};
  assign grant_idx = (grant_sum >= (ID_W+1)'(NUM_KEYS)) ?
                     ID_W'(grant_sum - (ID_W+1)'(NUM_KEYS)) : ID_W'(grant_sum);
  assign grant_oh  = grant_vld ? (NUM_KEYS'(1) << grant_idx) : '0;
  assign push_word = {pend_long_q[grant_idx], grant_idx};

  // Pending-slot update: a grant frees the slot on the same edge, so a key
  // can re-raise while being granted without counting as a drop.
  always_comb begin
    pend_kept   = pending_q & ~grant_oh;
    drop        = raise & pend_kept;
    pending_d   = pend_kept | raise;
    pend_long_d = pend_long_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (raise[k] && !pend_kept[k]) pend_long_d[k] = raise_long[k];
    end
    overflow_d = (|drop) | (overflow_q & ~clr_ovf);
    if (!grant_vld)                              rr_d = rr_q;
    else if (grant_idx == ID_W'(NUM_KEYS - 1))   rr_d = '0;
    else                                         rr_d = grant_idx + ID_W'(1);
  end

  // Arbiter and pending-slot state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q   <= '0;
      pend_long_q <= '0;
      rr_q        <= '0;
      overflow_q  <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      pend_long_q <= pend_long_d;
      rr_q        <= rr_d;
      overflow_q  <= overflow_d;
    end
  end

  key_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (grant_vld),
    .din_i   (push_word),
    .pop_i   (evt_ready),
    .dout_o  (head_word),
    .full_o  (fifo_full_w),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_key   = head_word[ID_W-1:0];
  assign evt_long  = head_word[ID_W];
  assign fifo_full = fifo_full_w;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: directed scenarios plus a long
// randomized run compared against an event-level reference model.
module tb_key_event_ctrl;

  localparam int N     = 4;
  localparam int IDW   = 2;
  localparam int LC    = 50;
  localparam int CW    = 6;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   key_press;
  logic [N-1:0]   key_stable;
  logic           evt_ready;
  logic           clr_ovf;
  logic           evt_valid;
  logic [IDW-1:0] evt_key;
  logic           evt_long;
  logic           fifo_full;
  logic           overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  key_event_ctrl #(
    .NUM_KEYS(N), .ID_W(IDW), .LONG_CYC(LC), .CNT_W(CW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .key_press(key_press), .key_stable(key_stable),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_long(evt_long), .fifo_full(fifo_full), .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  // ---------------- reference model (event level) ----------------
  // armed: key saw a press and is timing its hold; held: sampled hold cycles;
  // spent: long event already reported for this hold.
  bit m_armed [N];
  int m_held  [N];
  bit m_spent [N];
  bit m_pend  [N];
  bit m_plong [N];
  int m_rr;
  bit m_ovf;
  int m_q[$];   // entries: key*2 + long

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_armed[i] = 0; m_held[i] = 0; m_spent[i] = 0; m_pend[i] = 0; m_plong[i] = 0;
    end
    m_rr = 0;
    m_ovf = 0;
    m_q.delete();
  endfunction

  function automatic void model_step();
    bit had_head = (m_q.size() > 0);
    bit was_full = (m_q.size() == DEPTH);
    bit dropped  = 0;
    if (!was_full) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (m_pend[i]) begin
          m_q.push_back(i * 2 + int'(m_plong[i]));
          m_pend[i] = 0;
          m_rr = (i + 1) % N;
          break;
        end
      end
    end
    if (had_head && evt_ready) void'(m_q.pop_front());
    for (int i = 0; i < N; i++) begin
      int kind;
      kind = -1;
      if (m_spent[i]) begin
        if (!key_stable[i]) m_spent[i] = 0;
      end else if (m_armed[i]) begin
        if (!key_stable[i]) begin
          kind = 0; m_armed[i] = 0;
        end else if (m_held[i] == LC - 1) begin
          kind = 1; m_armed[i] = 0; m_spent[i] = 1;
        end else begin
          m_held[i]++;
        end
      end else if (key_press[i]) begin
        m_armed[i] = 1; m_held[i] = 0;
      end
      if (kind >= 0) begin
        if (m_pend[i]) dropped = 1;
        else begin
          m_pend[i] = 1; m_plong[i] = (kind == 1);
        end
      end
    end
    if (clr_ovf) m_ovf = 0;
    if (dropped) m_ovf = 1;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; drives one clock cycle and returns at the next negedge.
  task automatic drive_cycle(input logic [N-1:0] p, input logic [N-1:0] s,
                             input logic r, input logic c);
    key_press  = p;
    key_stable = s;
    evt_ready  = r;
    clr_ovf    = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    key_press = '0; key_stable = '0; evt_ready = 0; clr_ovf = 0;
    reset = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  // Press + immediate release on one key, then one idle cycle.
  task automatic short_evt(input int k, input logic r);
    logic [N-1:0] oh;
    oh = N'(1) << k;
    drive_cycle(oh, oh, r, 0);
    drive_cycle('0, '0, r, 0);
    drive_cycle('0, '0, r, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 0; key_press = '0; key_stable = '0; evt_ready = 0; clr_ovf = 0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({evt_valid, evt_key, evt_long, fifo_full, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b k=%0d l=%b f=%b o=%b exp all 0",
               evt_valid, evt_key, evt_long, fifo_full, overflow);
    end
    reset = 1;
    drive_cycle('0, '0, 1, 0);
    checks++;
    if ({evt_valid, evt_key, evt_long, fifo_full, overflow} !== '0) begin
      failures++;
      $display("FAIL post_reset_outputs got v=%b k=%0d l=%b f=%b o=%b exp all 0",
               evt_valid, evt_key, evt_long, fifo_full, overflow);
    end
  endtask

  task automatic test_short_press();
    drive_cycle(4'b0010, 4'b0010, 1, 0);
    repeat (10) drive_cycle('0, 4'b0010, 1, 0);
    drive_cycle('0, '0, 1, 0);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++; $display("FAIL short_early_valid got=%b exp=0", evt_valid);
    end
    drive_cycle('0, '0, 1, 0);
    checks++;
    if (evt_valid !== 1'b1 || evt_key !== 2'd1 || evt_long !== 1'b0) begin
      failures++;
      $display("FAIL short_event got v=%b k=%0d l=%b exp v=1 k=1 l=0", evt_valid, evt_key, evt_long);
    end
    drive_cycle('0, '0, 1, 0);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++; $display("FAIL short_one_cycle got=%b exp=0", evt_valid);
    end
  endtask

  task automatic test_long_press();
    int seen = 0;
    int first_idx = -1;
    int k_seen = -1;
    int l_seen = -1;
    drive_cycle(4'b0100, 4'b0100, 1, 0);
    for (int idx = 1; idx < 120; idx++) begin
      drive_cycle('0, 4'b0100, 1, 0);
      if (evt_valid === 1'b1) begin
        if (seen == 0) begin
          first_idx = idx; k_seen = int'(evt_key); l_seen = int'(evt_long);
        end
        seen++;
      end
    end
    for (int idx = 0; idx < 6; idx++) begin
      drive_cycle('0, '0, 1, 0);
      if (evt_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 1) begin
      failures++; $display("FAIL long_count got=%0d exp=1", seen);
    end
    checks++;
    if (first_idx != LC + 1) begin
      failures++; $display("FAIL long_latency got=%0d exp=%0d", first_idx, LC + 1);
    end
    checks++;
    if (k_seen != 2 || l_seen != 1) begin
      failures++; $display("FAIL long_event got k=%0d l=%0d exp k=2 l=1", k_seen, l_seen);
    end
  endtask

  task automatic test_simultaneous();
    int exp_k[3] = '{0, 1, 3};
    do_reset();
    drive_cycle(4'b1011, 4'b1011, 1, 0);
    repeat (3) drive_cycle('0, 4'b1011, 1, 0);
    drive_cycle('0, '0, 1, 0);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++; $display("FAIL simul_early_valid got=%b exp=0", evt_valid);
    end
    for (int j = 0; j < 3; j++) begin
      drive_cycle('0, '0, 1, 0);
      checks++;
      if (evt_valid !== 1'b1 || int'(evt_key) != exp_k[j] || evt_long !== 1'b0) begin
        failures++;
        $display("FAIL simul_order[%0d] got v=%b k=%0d l=%b exp v=1 k=%0d l=0",
                 j, evt_valid, evt_key, evt_long, exp_k[j]);
      end
    end
    drive_cycle('0, '0, 1, 0);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++; $display("FAIL simul_drained got=%b exp=0", evt_valid);
    end
    // Pointer should be back at 0: keys 3 and 0 together -> 0 wins first.
    drive_cycle(4'b1001, 4'b1001, 1, 0);
    drive_cycle('0, '0, 1, 0);
    drive_cycle('0, '0, 1, 0);
    checks++;
    if (evt_valid !== 1'b1 || evt_key !== 2'd0) begin
      failures++; $display("FAIL simul_ptr_wrap got v=%b k=%0d exp v=1 k=0", evt_valid, evt_key);
    end
    drive_cycle('0, '0, 1, 0);
    checks++;
    if (evt_valid !== 1'b1 || evt_key !== 2'd3) begin
      failures++; $display("FAIL simul_ptr_second got v=%b k=%0d exp v=1 k=3", evt_valid, evt_key);
    end
    drive_cycle('0, '0, 1, 0);
  endtask

  task automatic test_backpressure();
    int seq[6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int j = 0; j < 6; j++) begin
      short_evt(seq[j], 0);
      if (j == 3) begin
        checks++;
        if (fifo_full !== 1'b1) begin
          failures++; $display("FAIL bp_full_after4 got=%b exp=1", fifo_full);
        end
      end
    end
    checks++;
    if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
      failures++; $display("FAIL bp_hold got full=%b ovf=%b exp full=1 ovf=0", fifo_full, overflow);
    end
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (evt_valid !== 1'b1 || int'(evt_key) != seq[j] || evt_long !== 1'b0) begin
        failures++;
        $display("FAIL bp_drain[%0d] got v=%b k=%0d l=%b exp v=1 k=%0d l=0",
                 j, evt_valid, evt_key, evt_long, seq[j]);
      end
      drive_cycle('0, '0, 1, 0);
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++; $display("FAIL bp_empty got=%b exp=0", evt_valid);
    end
  endtask

  task automatic test_overflow();
    int seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int j = 0; j < 5; j++) short_evt(seq[j], 0);
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_none_yet got=%b exp=0", overflow);
    end
    short_evt(0, 0);
    checks++;
    if (overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_set got=%b exp=1", overflow);
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (evt_valid !== 1'b1 || int'(evt_key) != seq[j]) begin
        failures++;
        $display("FAIL ovf_drain[%0d] got v=%b k=%0d exp v=1 k=%0d", j, evt_valid, evt_key, seq[j]);
      end
      drive_cycle('0, '0, 1, 0);
    end
    checks++;
    if (evt_valid !== 1'b0 || overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_single got v=%b ovf=%b exp v=0 ovf=1", evt_valid, overflow);
    end
    drive_cycle('0, '0, 1, 1);
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_clear got=%b exp=0", overflow);
    end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    do_reset();
    short_evt(0, 0);
    short_evt(2, 0);
    short_evt(3, 0);
    drive_cycle(4'b0010, 4'b0010, 0, 0);
    drive_cycle('0, 4'b0010, 0, 0);
    reset = 0;
    model_reset();
    #1;
    checks++;
    if (evt_valid !== 1'b0 || fifo_full !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async got v=%b f=%b o=%b exp all 0", evt_valid, fifo_full, overflow);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    for (int j = 0; j < 10; j++) begin
      drive_cycle('0, '0, 1, 0);
      if (evt_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++; $display("FAIL rst_mid_stray got=%0d exp=0", stray);
    end
    short_evt(1, 1);
    checks++;
    if (evt_valid !== 1'b1 || evt_key !== 2'd1 || evt_long !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_key1_idle got v=%b k=%0d l=%b exp v=1 k=1 l=0", evt_valid, evt_key, evt_long);
    end
    drive_cycle('0, '0, 1, 0);
  endtask

  task automatic test_random();
    logic [N-1:0] stab = '0;
    logic [N-1:0] prs;
    logic         rdy;
    int           bad = 0;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 29) == 0) stab[i] = ~stab[i];
        prs[i] = ($urandom_range(0, 15) == 0);
      end
      if ((cyc / 200) % 2 == 0) rdy = ($urandom_range(0, 3) != 0);
      else                      rdy = ($urandom_range(0, 7) == 0);
      drive_cycle(prs, stab, rdy, ($urandom_range(0, 63) == 0));
      checks++;
      if (evt_valid !== (m_q.size() > 0) || fifo_full !== (m_q.size() == DEPTH) ||
          overflow !== m_ovf) begin
        failures++; bad++;
        if (bad < 10)
          $display("FAIL rand_flags cyc=%0d got v=%b f=%b o=%b exp v=%b f=%b o=%b", cyc,
                   evt_valid, fifo_full, overflow, (m_q.size() > 0), (m_q.size() == DEPTH), m_ovf);
      end
      if (m_q.size() > 0) begin
        checks++;
        if (int'(evt_key) != m_q[0] / 2 || int'(evt_long) != m_q[0] % 2) begin
          failures++; bad++;
          if (bad < 10)
            $display("FAIL rand_head cyc=%0d got k=%0d l=%b exp k=%0d l=%0d", cyc,
                     evt_key, evt_long, m_q[0] / 2, m_q[0] % 2);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_press();
    test_simultaneous();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
